conv1d_pe_sequencer: RTL and testbench
======================================

Name: conv1d_pe_sequencer

Overview:
Control FSM that drives one PE group (Para_Deg parallel multiply-accumulate lanes with a registered accumulator) through a stride-1 1-D convolution. It issues weight, input and partial-sum buffer reads for each tile of Para_Deg outputs. It pulses Initial_Accumulate on the first tap of each tile and writes the finished tile back to the output buffer. It sits between the top-level conv controller (start/done) and the PE group plus its three synchronous-read buffers.

Parameters:
Para_Deg, 4, outputs per tile (PE lanes); input address stride per tile
TAP_W, 4, width of tap count/weight address (max taps 2^TAP_W-1)
TILE_W, 6, width of tile count/output-buffer address
IN_ADDR_W, 10, input-buffer address width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse, begin a run (ignored while busy)
cfg_taps  input  TAP_W  kernel length K, sampled on accepted start
cfg_tiles  input  TILE_W  tile count T, sampled on accepted start
cfg_first_pass  input  1  1 = ignore old partial sums (start from zero), sampled on start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse, run complete
wb_rd_en  output  1  weight-buffer read strobe
wb_rd_addr  output  TAP_W  weight index k
ib_rd_en  output  1  input-buffer read strobe
ib_rd_addr  output  IN_ADDR_W  t*Para_Deg + k (buffer returns Para_Deg consecutive words)
ob_rd_en  output  1  partial-sum read strobe
ob_rd_addr  output  TILE_W  tile index t
pe_init  output  1  to PE group Initial_Accumulate
pe_old_zero  output  1  forces PE old_output input to zero
ob_wr_en  output  1  write PE result to output buffer
ob_wr_addr  output  TILE_W  tile index t of result being written

Behaviour:
- Reset (async): state IDLE, counters 0, pipeline valids 0; all outputs 0.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE + start: latch cfg. If K==0 or T==0 go to FINISH; else go to ISSUE with k=0, t=0. busy=1 from the following cycle.
- ISSUE, stage 0: each cycle assert wb_rd_en/ib_rd_en with the addresses for (t,k).
  - k==0: also ob_rd_en=!first_pass, ob_rd_addr=t.
  - Advance k; on k==K-1 wrap k=0 and t++.
  - After issuing (T-1,K-1) go to DRAIN.
  - One issue per cycle, no stalls: the PE group accumulates every cycle and cannot hold.
- Stage 1 (buffer data valid at PE inputs) is one cycle after issue.
  - pe_init=1 exactly when stage-1 tap==0.
  - pe_old_zero = first_pass on those cycles, else 0.
- Stage 2 is one cycle after the stage-1 cycle of tap K-1 (accumulator now final). Assert ob_wr_en=1, ob_wr_addr=t for exactly that cycle.
  - Writes of tile t and reads of tile t+1 target different addresses, so there is no hazard.
- DRAIN: wait until the last stage-2 write has issued, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Latency: first ob_wr_en is K+1 cycles after the first issue. Total run is T*K issue cycles + 2 drain cycles + 1 FINISH cycle.
- K==1: pe_init and ob_wr_en are high every pipelined cycle (back-to-back tiles).
- ib_rd_addr is computed modulo 2^IN_ADDR_W (wraps, no error).
- start while busy (including the done cycle): ignored, cfg not re-latched.
- Reset mid-run: immediate abort to IDLE, no done pulse, no further writes.

Test Plan:
- K=3, T=2, first_pass=1, Para_Deg=4 -> ib_rd_addr 0,1,2,4,5,6 on consecutive cycles; pe_init high on stage-1 cycles 1 and 4 with pe_old_zero=1; ob_wr_en at cycles 4 and 7 with addr 0,1; done at cycle 9.
- Same run with first_pass=0 and PE group plus buffers attached; old partial sums 10/20 and all data/weights = 1 -> written tiles equal old+3 per lane (13, 23).
- K=1, T=4 -> pe_init and ob_wr_en each high for 4 consecutive cycles, addresses 0..3, one write per tile.
- K=0, or T=0 -> no read/write strobes, done pulses 2 cycles after start, busy high for exactly 1 cycle.
- start pulsed again mid-run with different cfg -> ignored; addresses and write count match the original cfg.
- reset asserted (async, mid-clock) during tile 1 of K=4, T=3 -> all outputs 0 immediately, no done, a new start runs cleanly from t=0.

Source files
------------

// File: rtl/conv1d_pe_sequencer.sv
// Sequencer that drives one PE group through a stride-1 1-D convolution.
// For each tile it issues buffer reads, marks the first tap for the PE group and writes the finished tile back.
module conv1d_pe_sequencer #(
  parameter int Para_Deg  = 4,
  parameter int TAP_W     = 4,
  parameter int TILE_W    = 6,
  parameter int IN_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TAP_W-1:0]     cfg_taps,
  input  logic [TILE_W-1:0]    cfg_tiles,
  input  logic                 cfg_first_pass,
  output logic                 busy,
  output logic                 done,
  output logic                 wb_rd_en,
  output logic [TAP_W-1:0]     wb_rd_addr,
  output logic                 ib_rd_en,
  output logic [IN_ADDR_W-1:0] ib_rd_addr,
  output logic                 ob_rd_en,
  output logic [TILE_W-1:0]    ob_rd_addr,
  output logic                 pe_init,
  output logic                 pe_old_zero,
  output logic                 ob_wr_en,
  output logic [TILE_W-1:0]    ob_wr_addr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]        state;
  logic [TAP_W-1:0]  taps_q;
  logic [TILE_W-1:0] tiles_q;
  logic              first_pass_q;
  logic [TAP_W-1:0]  k;
  logic [TILE_W-1:0] t;
  logic              done_q;

  // Stage 1: buffer data at PE inputs. Stage 2: accumulator holds the finished tile.
  logic              s1_valid;
  logic [TAP_W-1:0]  s1_tap;
  logic [TILE_W-1:0] s1_tile;
  logic              s2_valid;
  logic [TILE_W-1:0] s2_tile;

  logic              issue;
  logic              last_tap;
  logic              last_tile;
  logic [IN_ADDR_W-1:0] ib_addr_calc;

  assign issue     = (state == ISSUE);
  assign last_tap  = (k == taps_q - TAP_W'(1));
  assign last_tile = (t == tiles_q - TILE_W'(1));
  // Truncation to IN_ADDR_W gives the intended modulo wrap of the input address.
  assign ib_addr_calc = IN_ADDR_W'(t) * IN_ADDR_W'(Para_Deg) + IN_ADDR_W'(k);

  // NOTE: every register here uses non-blocking assignment so all stages see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      taps_q       <= '0;
      tiles_q      <= '0;
      first_pass_q <= 1'b0;
      k            <= '0;
      t            <= '0;
      done_q       <= 1'b0;
      s1_valid     <= 1'b0;
      s1_tap       <= '0;
      s1_tile      <= '0;
      s2_valid     <= 1'b0;
      s2_tile      <= '0;
    end else begin
      done_q   <= (state == FINISH);
      s1_valid <= issue;
      s1_tap   <= k;
      s1_tile  <= t;
      s2_valid <= s1_valid && (s1_tap == taps_q - TAP_W'(1));
      s2_tile  <= s1_tile;

      case (state)
        IDLE: begin
          // The done cycle is already back in IDLE, so a start there is still refused.
          if (start && !done_q) begin
            taps_q       <= cfg_taps;
            tiles_q      <= cfg_tiles;
            first_pass_q <= cfg_first_pass;
            k            <= '0;
            t            <= '0;
            state        <= (cfg_taps == '0 || cfg_tiles == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (last_tap) begin
            k <= '0;
            t <= t + TILE_W'(1);
            if (last_tile) state <= DRAIN;
          end else begin
            k <= k + TAP_W'(1);
          end
        end
        DRAIN: begin
          if (s2_valid && !s1_valid) state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign wb_rd_en    = issue;
  assign wb_rd_addr  = issue ? k : '0;
  assign ib_rd_en    = issue;
  assign ib_rd_addr  = issue ? ib_addr_calc : '0;
  assign ob_rd_en    = issue && (k == '0) && !first_pass_q;
  assign ob_rd_addr  = ob_rd_en ? t : '0;
  assign pe_init     = s1_valid && (s1_tap == '0);
  assign pe_old_zero = pe_init && first_pass_q;
  assign ob_wr_en    = s2_valid;
  assign ob_wr_addr  = s2_valid ? s2_tile : '0;

endmodule

// File: tb/tb_conv1d_pe_sequencer.sv
// Randomised bench for conv1d_pe_sequencer: a cycle-indexed run model plus a small PE/buffer harness
// whose written tiles are compared with convolution sums computed directly from the memories.
module tb_conv1d_pe_sequencer;
  localparam int PD = 4;
  localparam int TAP_W = 4;
  localparam int TILE_W = 6;
  localparam int IN_ADDR_W = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [TAP_W-1:0]     cfg_taps = '0;
  logic [TILE_W-1:0]    cfg_tiles = '0;
  logic                 cfg_first_pass = 1'b0;
  logic                 busy, done, wb_rd_en, ib_rd_en, ob_rd_en, pe_init, pe_old_zero, ob_wr_en;
  logic [TAP_W-1:0]     wb_rd_addr;
  logic [IN_ADDR_W-1:0] ib_rd_addr;
  logic [TILE_W-1:0]    ob_rd_addr, ob_wr_addr;

  conv1d_pe_sequencer #(.Para_Deg(PD), .TAP_W(TAP_W), .TILE_W(TILE_W), .IN_ADDR_W(IN_ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_taps(cfg_taps), .cfg_tiles(cfg_tiles),
    .cfg_first_pass(cfg_first_pass), .busy(busy), .done(done),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .ib_rd_en(ib_rd_en), .ib_rd_addr(ib_rd_addr),
    .ob_rd_en(ob_rd_en), .ob_rd_addr(ob_rd_addr), .pe_init(pe_init), .pe_old_zero(pe_old_zero),
    .ob_wr_en(ob_wr_en), .ob_wr_addr(ob_wr_addr)
  );

  always #5 clk = ~clk;

  // Buffers and PE group: synchronous reads, accumulator updated every cycle.
  int wmem [16];
  int imem [1024];
  int old_mem [64][PD];
  int wr_mem [64][PD];
  int w_q;
  int in_q [PD];
  int old_q [PD];
  int acc [PD];

  always @(posedge clk) begin
    if (wb_rd_en) w_q <= wmem[wb_rd_addr];
    for (int l = 0; l < PD; l++) begin
      if (ib_rd_en) in_q[l] <= imem[(int'(ib_rd_addr) + l) & 1023];
      if (ob_rd_en) old_q[l] <= old_mem[ob_rd_addr][l];
      if (pe_init) acc[l] <= (pe_old_zero ? 0 : old_q[l]) + w_q * in_q[l];
      else         acc[l] <= acc[l] + w_q * in_q[l];
      if (ob_wr_en) wr_mem[ob_wr_addr][l] <= acc[l];
    end
  end

  // Run model: a run is a cycle index c counted from the first issue cycle.
  bit m_active = 1'b0;
  int m_c, m_K, m_T, m_fp, m_end;
  int lit_mode = 0;
  int lit_ib [6] = '{0, 1, 2, 4, 5, 6};
  int vectors = 0;
  int misses = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      misses++;
      $display("FAIL %s: got %0d, want %0d (run cycle %0d, K=%0d T=%0d) @%0t", name, act, exp, m_c, m_K, m_T, $time);
    end
  endtask

  int n, c, tt, kk, e_busy, e_done, e_issue, e_init, e_wr, e_wr_addr, e_ob_rd;
  bit triv;

  always @(negedge clk) begin
    if (reset) m_active = 1'b0;
    c    = m_c;
    n    = m_K * m_T;
    triv = (m_K == 0) || (m_T == 0);
    e_busy = 0; e_done = 0; e_issue = 0; e_init = 0; e_wr = 0; e_wr_addr = 0; e_ob_rd = 0;
    tt = 0; kk = 0;
    if (m_active) begin
      e_busy = triv ? int'(c == 0) : int'(c <= n + 2);
      e_done = triv ? int'(c == 1) : int'(c == n + 3);
      if (!triv) begin
        if (c < n) begin
          e_issue = 1; tt = c / m_K; kk = c % m_K;
          e_ob_rd = int'(kk == 0 && m_fp == 0);
        end
        e_init = int'(c >= 1 && c - 1 < n && (c - 1) % m_K == 0);
        if (c >= m_K + 1 && (c - 1) % m_K == 0 && (c - 1) / m_K <= m_T) begin
          e_wr = 1; e_wr_addr = (c - 1) / m_K - 1;
        end
      end
    end
    check("busy", int'(busy), e_busy);
    check("done", int'(done), e_done);
    check("wb_rd_en", int'(wb_rd_en), e_issue);
    check("ib_rd_en", int'(ib_rd_en), e_issue);
    if (e_issue != 0) begin
      check("wb_rd_addr", int'(wb_rd_addr), kk);
      check("ib_rd_addr", int'(ib_rd_addr), (tt * PD + kk) & 1023);
    end
    check("ob_rd_en", int'(ob_rd_en), e_ob_rd);
    if (e_ob_rd != 0) check("ob_rd_addr", int'(ob_rd_addr), tt);
    check("pe_init", int'(pe_init), e_init);
    check("pe_old_zero", int'(pe_old_zero), (e_init != 0 && m_fp != 0) ? 1 : 0);
    check("ob_wr_en", int'(ob_wr_en), e_wr);
    if (e_wr != 0) check("ob_wr_addr", int'(ob_wr_addr), e_wr_addr);

    // Hand-derived expectations for K=3, T=2 that pin the model above.
    if (m_active && lit_mode == 1) begin
      check("lit_ib_en", int'(ib_rd_en), int'(c < 6));
      if (c < 6) check("lit_ib_addr", int'(ib_rd_addr), lit_ib[c]);
      check("lit_pe_init", int'(pe_init), int'(c == 1 || c == 4));
      check("lit_old_zero", int'(pe_old_zero), int'(c == 1 || c == 4));
      check("lit_wr_en", int'(ob_wr_en), int'(c == 4 || c == 7));
      if (c == 4 || c == 7) check("lit_wr_addr", int'(ob_wr_addr), (c == 4) ? 0 : 1);
      check("lit_done", int'(done), int'(c == 9));
    end
    if (m_active && lit_mode == 2 && c == 9)
      for (int l = 0; l < PD; l++) begin
        check("lit_tile0", wr_mem[0][l], 13);
        check("lit_tile1", wr_mem[1][l], 23);
      end

    // Every written tile must equal old (unless first pass) plus the K-tap dot product per lane.
    if (m_active && !triv && c == m_end)
      for (int t = 0; t < m_T; t++)
        for (int l = 0; l < PD; l++) begin
          int e;
          e = (m_fp != 0) ? 0 : old_mem[t][l];
          for (int k = 0; k < m_K; k++) e += wmem[k] * imem[(t * PD + l + k) & 1023];
          check("tile_data", wr_mem[t][l], e);
        end

    if (!reset) begin
      if (m_active) begin
        if (m_c == m_end) m_active = 1'b0;
        else m_c++;
      end else if (start) begin
        m_active = 1'b1; m_c = 0;
        m_K = int'(cfg_taps); m_T = int'(cfg_tiles); m_fp = int'(cfg_first_pass);
        m_end = (m_K == 0 || m_T == 0) ? 1 : m_K * m_T + 3;
      end
    end
  end

  task automatic fill(input bit ones);
    for (int i = 0; i < 16; i++) wmem[i] = ones ? 1 : int'($urandom_range(0, 15));
    for (int i = 0; i < 1024; i++) imem[i] = ones ? 1 : int'($urandom_range(0, 15));
    for (int t = 0; t < 64; t++)
      for (int l = 0; l < PD; l++) old_mem[t][l] = ones ? 10 * (t + 1) : int'($urandom_range(0, 255));
  endtask

  task automatic launch(input int k, input int t, input int fp);
    @(posedge clk); #1;
    cfg_taps = TAP_W'(k); cfg_tiles = TILE_W'(t); cfg_first_pass = 1'(fp); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_taps = TAP_W'($urandom); cfg_tiles = TILE_W'($urandom); cfg_first_pass = 1'($urandom);
  endtask

  // glitch: -1 none, -2 pulse start in the done cycle, otherwise pulse start at that run cycle.
  task automatic wait_end(input int glitch);
    for (int i = 0; i < 2000 && m_active; i++) begin
      start = (glitch == -2) ? (m_c == m_end) : (m_c == glitch);
      if (start) begin cfg_taps = TAP_W'($urandom); cfg_tiles = TILE_W'($urandom); end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, input int t, input int fp, input int glitch);
    launch(k, t, fp);
    wait_end(glitch);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(1'b0);
    #12 reset = 1'b0;
    repeat (2) @(posedge clk);

    lit_mode = 1; run(3, 2, 1, -1); lit_mode = 0;
    fill(1'b1);
    lit_mode = 2; run(3, 2, 0, -1); lit_mode = 0;
    fill(1'b0);
    run(1, 4, 0, -1);
    run(0, 3, 0, -1);
    run(2, 0, 1, -1);
    run(4, 3, 0, 5);
    run(4, 3, 1, -2);
    run(15, 63, 0, -1);

    // Asynchronous reset in the middle of tile 1, then a clean restart.
    launch(4, 3, 0);
    for (int i = 0; i < 200 && m_c != 5; i++) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    run(4, 3, 0, -1);

    for (int r = 0; r < 30; r++) begin
      int g;
      fill(1'b0);
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      if ($urandom_range(0, 5) == 0) g = -2;
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), int'($urandom_range(0, 1)), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
